jogo_desafio_memoria: RTL and testbench

- Top-level "Simon"-style memory game for a 4-button / 4-LED board, clocked at 1 kHz.
- Each round, the block replays an internal fixed 16-entry sequence on the LEDs, up to the current round number.
- The player then repeats that prefix on the buttons.
- The game ends in win, loss (wrong button) or timeout. Debug outputs drive 7-segment displays.

---
 rtl/jogo_desafio_memoria.sv | 189 ++++++++++++++++++
 tb/tb_jogo_desafio_memoria.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_desafio_memoria.sv
// Simon-style memory game: replays a fixed 16-entry sequence on four LEDs, then
// checks the player's button presses against it round by round.
module jogo_desafio_memoria #(
  parameter int LED_ON_CYCLES  = 1000,
  parameter int LED_OFF_CYCLES = 20,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic       nivel,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic       db_tem_jogada,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_sequencia
);

  localparam int TMAX = (LED_ON_CYCLES > LED_OFF_CYCLES)
                        ? ((LED_ON_CYCLES > TIMEOUT_CYCLES) ? LED_ON_CYCLES : TIMEOUT_CYCLES)
                        : ((LED_OFF_CYCLES > TIMEOUT_CYCLES) ? LED_OFF_CYCLES : TIMEOUT_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_END  = TW'(LED_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_END = TW'(LED_OFF_CYCLES - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    FIM_GANHOU  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_PERDEU  = 4'hE
  } estado_t;

  function automatic logic [3:0] rom(input logic [3:0] idx);
    case (idx)
      4'd0:  rom = 4'h1;
      4'd1:  rom = 4'h2;
      4'd2:  rom = 4'h4;
      4'd3:  rom = 4'h8;
      4'd4:  rom = 4'h4;
      4'd5:  rom = 4'h2;
      4'd6:  rom = 4'h1;
      4'd7:  rom = 4'h1;
      4'd8:  rom = 4'h2;
      4'd9:  rom = 4'h2;
      4'd10: rom = 4'h4;
      4'd11: rom = 4'h4;
      4'd12: rom = 4'h8;
      4'd13: rom = 4'h8;
      4'd14: rom = 4'h1;
      default: rom = 4'h4;
    endcase
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  estado_t       estado, estado_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    rodada, rodada_n;
  logic [3:0]    pos, pos_n;
  logic [3:0]    jogada;
  logic          botao_prev;
  logic          tem_jogada;
  logic [3:0]    ultimo;
  logic          temporizado;

  assign tem_jogada = (|botoes) & ~botao_prev;
  assign ultimo     = nivel ? 4'd15 : 4'd7;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      timer      <= '0;
      rodada     <= '0;
      pos        <= '0;
      jogada     <= '0;
      botao_prev <= 1'b0;
    end else begin
      estado     <= estado_n;
      timer      <= timer_n;
      rodada     <= rodada_n;
      pos        <= pos_n;
      botao_prev <= |botoes;
      if (tem_jogada) jogada <= botoes;
    end
  end

  always_comb begin
    estado_n    = estado;
    pos_n       = pos;
    rodada_n    = rodada;
    temporizado = 1'b0;
    case (estado)
      INICIAL: if (jogar) estado_n = PREPARA;
      PREPARA: begin
        pos_n    = '0;
        rodada_n = '0;
        estado_n = MOSTRA;
      end
      MOSTRA: begin
        temporizado = 1'b1;
        if (timer == ON_END) estado_n = APAGA;
      end
      APAGA: begin
        temporizado = 1'b1;
        if (timer == OFF_END) begin
          if (pos < rodada) begin
            pos_n    = pos + 4'd1;
            estado_n = MOSTRA;
          end else begin
            pos_n    = '0;
            estado_n = ESPERA;
          end
        end
      end
      ESPERA: begin
        temporizado = 1'b1;
        if (tem_jogada)             estado_n = REGISTRA;
        else if (timer == TMO_END)  estado_n = FIM_TIMEOUT;
      end
      REGISTRA: estado_n = COMPARA;
      // Sequence values are one-hot, so any multi-button press mismatches here.
      COMPARA: begin
        if (jogada != rom(pos)) begin
          estado_n = FIM_PERDEU;
        end else if (pos < rodada) begin
          pos_n    = pos + 4'd1;
          estado_n = ESPERA;
        end else if (rodada == ultimo) begin
          estado_n = FIM_GANHOU;
        end else begin
          rodada_n = rodada + 4'd1;
          pos_n    = '0;
          estado_n = MOSTRA;
        end
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) estado_n = PREPARA;
      default: estado_n = INICIAL;
    endcase
    timer_n = (temporizado && (estado_n == estado)) ? timer + 1'b1 : '0;
  end

  assign leds    = (estado == MOSTRA) ? rom(pos) : 4'h0;
  assign ganhou  = (estado == FIM_GANHOU);
  assign perdeu  = (estado == FIM_PERDEU);
  assign timeout = (estado == FIM_TIMEOUT);
  assign pronto  = ganhou | perdeu | timeout;

  assign db_tem_jogada  = tem_jogada;
  assign db_jogadafeita = hex7(jogada);
  assign db_contagem    = hex7(pos);
  assign db_memoria     = hex7(rom(pos));
  assign db_estado      = hex7(estado);
  assign db_sequencia   = hex7(rodada);

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// Directed bench for the memory game: plays full games, a loss, a timeout and a
// mid-game reset, with short display/timeout parameters to keep runs brief.
module tb_jogo_desafio_memoria;

  localparam int LON  = 20;
  localparam int LOFF = 4;
  localparam int TMO  = 100;

  localparam logic [3:0] ROM_Q [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  // Active-high gfedcba patterns; the display drives their complement.
  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic       nivel = 1'b1;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu, timeout, db_tem_jogada;
  logic [6:0] db_jogadafeita, db_contagem, db_memoria, db_estado, db_sequencia;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  jogo_desafio_memoria #(
    .LED_ON_CYCLES (LON),
    .LED_OFF_CYCLES(LOFF),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .jogar         (jogar),
    .botoes        (botoes),
    .nivel         (nivel),
    .leds          (leds),
    .pronto        (pronto),
    .ganhou        (ganhou),
    .perdeu        (perdeu),
    .timeout       (timeout),
    .db_tem_jogada (db_tem_jogada),
    .db_jogadafeita(db_jogadafeita),
    .db_contagem   (db_contagem),
    .db_memoria    (db_memoria),
    .db_estado     (db_estado),
    .db_sequencia  (db_sequencia)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input int v);
    return ~SEG_ON[v & 15];
  endfunction

  function automatic int unseg(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (seg(k) == s) return k;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Rules that hold on every cycle regardless of game phase.
  always @(negedge clock) begin
    if (armed) begin
      chk("leds_only_in_mostra", (leds != 4'h0), (db_estado == seg(2)));
      chk("pronto_is_any_flag", pronto, (ganhou | perdeu | timeout));
      chk("at_most_one_flag", ((ganhou + perdeu + timeout) <= 1), 1);
      chk("memoria_tracks_pos", db_memoria, seg(ROM_Q[unseg(db_contagem)]));
    end
  end

  task automatic wait_state(input int code, input int limit, output int n);
    n = 0;
    while (db_estado != seg(code) && n < limit) begin
      tick();
      n++;
    end
    chk($sformatf("reach_state_%0h", code), db_estado, seg(code));
  endtask

  task automatic start_game();
    jogar = 1'b1;
    fork
      begin
        repeat (5) @(negedge clock);
        jogar = 1'b0;
      end
    join_none
    tick();
    chk("prepara_state", db_estado, seg(1));
    chk("prepara_flags", {pronto, ganhou, perdeu, timeout}, 4'b0000);
  endtask

  // Display phase of round r (0-based): elements 0..r, each lit then dark.
  task automatic display_round(input int r);
    int n;
    wait_state(2, 10, n);
    for (int i = 0; i <= r; i++) begin
      chk($sformatf("contagem_r%0d_i%0d", r, i), db_contagem, seg(i));
      for (int c = 0; c < LON; c++) begin
        chk($sformatf("led_on_r%0d_i%0d", r, i), leds, ROM_Q[i]);
        tick();
      end
      for (int c = 0; c < LOFF; c++) begin
        chk($sformatf("led_off_r%0d_i%0d", r, i), leds, 4'h0);
        tick();
      end
    end
    chk($sformatf("espera_after_r%0d", r), db_estado, seg(5));
    chk($sformatf("sequencia_r%0d", r), db_sequencia, seg(r));
  endtask

  task automatic press(input logic [3:0] v, input int hold, input bit last);
    int extra;
    extra = 0;
    botoes = v;
    #1;
    chk("tem_jogada_pulse", db_tem_jogada, 1'b1);
    for (int h = 1; h < hold; h++) begin
      tick();
      #1;
      if (db_tem_jogada) extra++;
    end
    chk("no_repeat_pulse", extra, 0);
    tick();
    botoes = 4'h0;
    if (!last) begin
      tick();
      tick();
    end
  endtask

  task automatic play_round(input int r, input int hold_first);
    for (int i = 0; i <= r; i++)
      press(ROM_Q[i], (i == 0) ? hold_first : 2, (i == r));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    armed = 1'b1;
    chk("reset_estado_lit", db_estado, 7'h40);
    chk("reset_leds", leds, 4'h0);
    chk("reset_flags", {pronto, ganhou, perdeu, timeout}, 4'b0000);
    chk("reset_sequencia", db_sequencia, seg(0));
    chk("reset_contagem", db_contagem, seg(0));
    chk("reset_memoria_lit", db_memoria, 7'h79);
    chk("reset_jogada", db_jogadafeita, seg(0));
    tick();
    chk("idle_stays_inicial", db_estado, seg(0));

    // Full 16-round win; round 2 opens with a long button hold.
    nivel = 1'b1;
    start_game();
    for (int r = 0; r < 16; r++) begin
      display_round(r);
      play_round(r, (r == 1) ? 10 : 2);
    end
    tick();
    chk("win16_ganhou", ganhou, 1'b1);
    chk("win16_pronto", pronto, 1'b1);
    chk("win16_others", {perdeu, timeout}, 2'b00);
    chk("win16_estado_lit", db_estado, 7'h08);
    chk("win16_sequencia", db_sequencia, seg(15));
    repeat (3) tick();
    chk("win16_holds", ganhou, 1'b1);

    // 8-round game; nivel dropped shortly after the start request.
    start_game();
    nivel = 1'b0;
    for (int r = 0; r < 8; r++) begin
      display_round(r);
      play_round(r, 2);
    end
    tick();
    chk("win8_ganhou", ganhou, 1'b1);
    chk("win8_pronto", pronto, 1'b1);
    chk("win8_sequencia", db_sequencia, seg(7));
    for (int c = 0; c < LON; c++) begin
      chk("win8_no_round9", leds, 4'h0);
      tick();
    end
    chk("win8_holds", db_estado, seg(10));

    // Loss: third round, second press is 8 where 2 is expected.
    nivel = 1'b1;
    start_game();
    display_round(0);
    play_round(0, 2);
    display_round(1);
    play_round(1, 2);
    display_round(2);
    press(4'h1, 2, 1'b0);
    press(4'h8, 2, 1'b1);
    tick();
    chk("loss_perdeu", perdeu, 1'b1);
    chk("loss_pronto", pronto, 1'b1);
    chk("loss_ganhou", ganhou, 1'b0);
    chk("loss_jogada_lit", db_jogadafeita, 7'h00);
    chk("loss_estado", db_estado, seg(14));

    // Timeout: no presses after the first display.
    start_game();
    display_round(0);
    wait_state(13, TMO + 10, n);
    chk("timeout_latency", n, TMO);
    chk("timeout_flag", timeout, 1'b1);
    chk("timeout_pronto", pronto, 1'b1);
    chk("timeout_others", {ganhou, perdeu}, 2'b00);
    chk("timeout_estado_lit", db_estado, 7'h21);

    // Restart clears the flags and replays from the first element.
    start_game();
    display_round(0);
    play_round(0, 2);
    display_round(1);
    play_round(1, 2);

    // Reset in the middle of round 3's display.
    wait_state(2, 10, n);
    repeat (3) tick();
    chk("pre_reset_leds", leds, ROM_Q[0]);
    chk("pre_reset_sequencia", db_sequencia, seg(2));
    reset = 1'b1;
    tick();
    chk("midreset_estado", db_estado, seg(0));
    chk("midreset_leds", leds, 4'h0);
    chk("midreset_flags", {pronto, ganhou, perdeu, timeout}, 4'b0000);
    chk("midreset_sequencia", db_sequencia, seg(0));
    chk("midreset_contagem", db_contagem, seg(0));
    reset = 1'b0;
    tick();
    chk("after_reset_idle", db_estado, seg(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
